// File: rtl/gs_bu_seq.sv
// rtl/gs_bu_seq.sv - Gentleman-Sande inverse-NTT butterfly (Q = 8380417) with a serial modular multiplier
// Computes A = (X+Y) mod Q and B = (X-Y)*TF mod Q, optionally scaled by 2^-1 mod Q.
module gs_bu_seq #(
  parameter bit HALVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [22:0] X,
  input  logic [22:0] Y,
  input  logic [22:0] TF,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] A,
  output logic [22:0] B
);

  localparam logic [23:0] Q = 24'd8380417;

  typedef enum logic [1:0] {IDLE, MUL, HALF, DONE} state_t;

  state_t      state, state_nx;
  logic [23:0] a_r, d_r, acc;
  logic [22:0] tf_r;
  logic [4:0]  cnt;

  logic [23:0] sum_w, a_in, d_in;
  logic [23:0] dbl, dbl_r, add, step;

  // Multiply by 2^-1 mod Q: odd values get Q added first so the shift is exact.
  function automatic logic [22:0] halve_mod(input logic [23:0] v);
    logic [23:0] t;
    t = v + (v[0] ? Q : 24'd0);
    return t[23:1];
  endfunction

  always_comb begin
    sum_w = {1'b0, X} + {1'b0, Y};
    a_in  = (sum_w >= Q) ? sum_w - Q : sum_w;
    d_in  = (X >= Y) ? {1'b0, X} - {1'b0, Y} : {1'b0, X} + Q - {1'b0, Y};
  end

  // One MSB-first double-and-add step; acc < Q keeps every intermediate below 2Q.
  always_comb begin
    dbl   = acc << 1;
    dbl_r = (dbl >= Q) ? dbl - Q : dbl;
    add   = dbl_r + d_r;
    step  = dbl_r;
    if (tf_r[cnt]) begin
      step = (add >= Q) ? add - Q : add;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = MUL;
      MUL:  if (cnt == 5'd0) state_nx = HALVE ? HALF : DONE;
      HALF: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      d_r  <= '0;
      acc  <= '0;
      tf_r <= '0;
      cnt  <= '0;
      A    <= '0;
      B    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r  <= a_in;
            d_r  <= d_in;
            tf_r <= TF;
            acc  <= '0;
            cnt  <= 5'd22;
          end
        end
        MUL: begin
          acc <= step;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0 && !HALVE) begin
            A <= a_r[22:0];
            B <= step[22:0];
          end
        end
        HALF: begin
          A <= halve_mod(a_r);
          B <= halve_mod(acc);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_gs_bu_seq.sv
// tb/tb_gs_bu_seq.sv - scoreboard bench for gs_bu_seq, HALVE=0 and HALVE=1 side by side
// Both instances share operands; expectations come from plain modular arithmetic.
module tb_gs_bu_seq;

  localparam longint QL   = 8380417;
  localparam longint INV2 = 4190209;

  typedef struct {
    logic [22:0] a;
    logic [22:0] b;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [22:0] x = '0, y = '0, tf = '0;
  logic        in_ready [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [22:0] a [2];
  logic [22:0] b [2];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q [2][$];
  int   hold [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gs_bu_seq #(.HALVE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .X(x), .Y(y), .TF(tf), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .A(a[0]), .B(b[0])
  );

  gs_bu_seq #(.HALVE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .X(x), .Y(y), .TF(tf), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .A(a[1]), .B(b[1])
  );

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic exp_t model(input longint xv, input longint yv, input longint tv,
                                 input bit hv, input int ac);
    exp_t   r;
    longint s, d, p;
    s = (xv + yv) % QL;
    d = (xv - yv + QL) % QL;
    p = (d * tv) % QL;
    if (hv) begin
      s = (s * INV2) % QL;
      p = (p * INV2) % QL;
    end
    r.a   = 23'(s);
    r.b   = 23'(p);
    r.acc = ac;
    return r;
  endfunction

  function automatic logic [22:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 23'd0;
      1:       return 23'd1;
      2:       return 23'(QL - 1);
      default: return 23'($urandom_range(0, 32'(QL - 1)));
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [22:0] xv, input logic [22:0] yv, input logic [22:0] tv,
                       input bit push);
    int guard = 0;
    while (!(in_ready[0] && in_ready[1])) begin
      if (!in_ready[0] && !in_ready[1]) begin
        in_valid = 1'($urandom_range(0, 1));
        x  = 23'($urandom);
        y  = 23'($urandom);
        tf = 23'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b1;
    x  = xv;
    y  = yv;
    tf = tv;
    @(negedge clk);
    in_valid = 1'b0;
    if (push) begin
      q[0].push_back(model(xv, yv, tv, 1'b0, cyc));
      q[1].push_back(model(xv, yv, tv, 1'b1, cyc));
    end
  endtask

  initial begin
    bit          prev_v [2];
    bit          held [2];
    logic [22:0] la [2];
    logic [22:0] lb [2];
    exp_t        e;
    for (int k = 0; k < 2; k++) begin
      out_ready[k] = 1'b0;
      prev_v[k] = 1'b0;
      held[k] = 1'b0;
      la[k] = '0;
      lb[k] = '0;
    end
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          prev_v[k] = 1'b0;
          held[k] = 1'b0;
          out_ready[k] = 1'b0;
        end else begin
          if (hold[k] > 0 && out_valid[k]) begin
            out_ready[k] = 1'b0;
            hold[k]--;
          end else begin
            out_ready[k] = ($urandom_range(0, 2) != 0);
          end
          if (out_valid[k]) begin
            if (held[k]) begin
              chk($sformatf("hold_A%0d", k), a[k], la[k]);
              chk($sformatf("hold_B%0d", k), b[k], lb[k]);
              chk($sformatf("busy_in_ready%0d", k), in_ready[k], 0);
            end
            if (q[k].size() == 0) begin
              total++;
              bad++;
              $display("FAIL spurious_out%0d: got A=%0d B=%0d expected no output", k, a[k], b[k]);
            end else begin
              if (!prev_v[k]) chk($sformatf("latency%0d", k), cyc - q[k][0].acc, 23 + k);
              if (out_ready[k]) begin
                e = q[k].pop_front();
                chk($sformatf("A%0d", k), a[k], e.a);
                chk($sformatf("B%0d", k), b[k], e.b);
              end
            end
            held[k] = !out_ready[k];
            la[k] = a[k];
            lb[k] = b[k];
          end else begin
            if (held[k]) chk($sformatf("valid_held%0d", k), 0, 1);
            held[k] = 1'b0;
          end
          prev_v[k] = out_valid[k];
        end
      end
    end
  end

  initial begin
    logic [22:0] dx [8];
    logic [22:0] dy [8];
    logic [22:0] dt [8];
    int          g;
    dx = '{23'd5, 23'd3, 23'd8380416, 23'd1, 23'd2, 23'd4, 23'd1, 23'd7};
    dy = '{23'd3, 23'd5, 23'd8380416, 23'd0, 23'd0, 23'd2, 23'd0, 23'd7};
    dt = '{23'd1, 23'd1, 23'd2, 23'd8380416, 23'd4190209, 23'd1, 23'd1, 23'd0};
    hold[0] = 0;
    hold[1] = 0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_in_ready%0d", k), in_ready[k], 1);
      chk($sformatf("rst_out_valid%0d", k), out_valid[k], 0);
      chk($sformatf("rst_A%0d", k), a[k], 0);
      chk($sformatf("rst_B%0d", k), b[k], 0);
    end
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        hold[0] = 10;
        hold[1] = 10;
      end
      issue(dx[i], dy[i], dt[i], 1'b1);
    end

    // Abort an operation partway through the multiply.
    issue(23'd5, 23'd7, 23'd123456, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_in_ready%0d", k), in_ready[k], 1);
      chk($sformatf("abort_out_valid%0d", k), out_valid[k], 0);
      chk($sformatf("abort_A%0d", k), a[k], 0);
      chk($sformatf("abort_B%0d", k), b[k], 0);
    end
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      issue(rnd_op(), rnd_op(), rnd_op(), 1'b1);
    end

    g = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain0", q[0].size(), 0);
    chk("drain1", q[1].size(), 0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
